// File: rtl/imem_fetch_sequencer_if.sv
// Bundle of the run-control, IMEM, datapath and debug signals of the fetch sequencer.
// The master modport is the sequencer itself; the slave modport is everything around it
// (control, instruction memory, datapath and debug port).
interface imem_fetch_sequencer_if;
    logic       run;
    logic       step;
    logic       halt_req;
    logic [7:0] instruction;
    logic       exec_done;
    logic       dbg_req;
    logic [7:0] dbg_addr;
    logic [7:0] imem_addr;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       ir_valid;
    logic       dbg_grant;
    logic [7:0] dbg_data;
    logic [7:0] retired;
    logic [1:0] state;

    modport master (
        input  run,
        input  step,
        input  halt_req,
        input  instruction,
        input  exec_done,
        input  dbg_req,
        input  dbg_addr,
        output imem_addr,
        output pc,
        output ir,
        output ir_valid,
        output dbg_grant,
        output dbg_data,
        output retired,
        output state
    );

    modport slave (
        output run,
        output step,
        output halt_req,
        output instruction,
        output exec_done,
        output dbg_req,
        output dbg_addr,
        input  imem_addr,
        input  pc,
        input  ir,
        input  ir_valid,
        input  dbg_grant,
        input  dbg_data,
        input  retired,
        input  state
    );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// Fetch sequencer and IMEM arbiter for the 8-bit core.
// Owns the PC, fetches one instruction per FETCH cycle into ir, waits in EXEC for the
// datapath to acknowledge, then resolves the next PC (sequential or relative jump).
// While halted, the IMEM read port is lent to the debug port.
module imem_fetch_sequencer #(
    parameter int         DEPTH    = 32,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic                      clk,
    input  logic                      reset,
    imem_fetch_sequencer_if.master    bus
);

    typedef enum logic [1:0] {
        HALTED = 2'b00,
        FETCH  = 2'b01,
        EXEC   = 2'b10
    } state_t;

    // DEPTH is a power of two, so wrapping the PC is a simple mask.
    localparam logic [7:0] PC_MASK = 8'(DEPTH - 1);
    localparam logic [1:0] OP_JUMP = 2'b11;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       ir_valid_q, ir_valid_d;
    logic       dbg_grant_q, dbg_grant_d;
    logic [7:0] dbg_data_q, dbg_data_d;
    logic [7:0] retired_q, retired_d;
    logic       step_mode_q, step_mode_d;
    logic       halt_pending_q, halt_pending_d;

    logic [7:0] jump_offset;
    logic [7:0] pc_next_seq;

    // Jump offset is ir[5:0] sign-extended to 8 bits; both candidates are masked to DEPTH.
    always_comb begin
        jump_offset = {{2{ir_q[5]}}, ir_q[5:0]};
        if (ir_q[7:6] == OP_JUMP) begin
            pc_next_seq = (pc_q + jump_offset) & PC_MASK;
        end else begin
            pc_next_seq = (pc_q + 8'd1) & PC_MASK;
        end
    end

    // IMEM address: debug port owns it only while halted and requesting.
    always_comb begin
        if ((state_q == HALTED) && bus.dbg_req) begin
            bus.imem_addr = bus.dbg_addr;
        end else begin
            bus.imem_addr = pc_q;
        end
    end

    // Next-state and next-register logic; ir_valid and dbg_grant are single-cycle pulses.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        ir_valid_d     = 1'b0;
        dbg_grant_d    = 1'b0;
        dbg_data_d     = dbg_data_q;
        retired_d      = retired_q;
        step_mode_d    = step_mode_q;
        halt_pending_d = halt_pending_q;

        case (state_q)
            HALTED: begin
                if (bus.run) begin
                    state_d     = FETCH;
                    step_mode_d = 1'b0;
                end else if (bus.step) begin
                    state_d     = FETCH;
                    step_mode_d = 1'b1;
                end else if (bus.dbg_req) begin
                    dbg_data_d  = bus.instruction;
                    dbg_grant_d = 1'b1;
                end
            end

            FETCH: begin
                ir_d       = bus.instruction;
                ir_valid_d = 1'b1;
                state_d    = EXEC;
                if (bus.halt_req) begin
                    halt_pending_d = 1'b1;
                end
            end

            EXEC: begin
                if (bus.exec_done) begin
                    retired_d = retired_q + 8'd1;
                    pc_d      = pc_next_seq;
                    if (halt_pending_q || bus.halt_req || step_mode_q) begin
                        state_d        = HALTED;
                        halt_pending_d = 1'b0;
                        step_mode_d    = 1'b0;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (bus.halt_req) begin
                    halt_pending_d = 1'b1;
                end
            end

            default: begin
                state_d = HALTED;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= HALTED;
            pc_q           <= RESET_PC;
            ir_q           <= 8'h00;
            ir_valid_q     <= 1'b0;
            dbg_grant_q    <= 1'b0;
            dbg_data_q     <= 8'h00;
            retired_q      <= 8'h00;
            step_mode_q    <= 1'b0;
            halt_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            ir_valid_q     <= ir_valid_d;
            dbg_grant_q    <= dbg_grant_d;
            dbg_data_q     <= dbg_data_d;
            retired_q      <= retired_d;
            step_mode_q    <= step_mode_d;
            halt_pending_q <= halt_pending_d;
        end
    end

    // Registered outputs.
    always_comb begin
        bus.pc        = pc_q;
        bus.ir        = ir_q;
        bus.ir_valid  = ir_valid_q;
        bus.dbg_grant = dbg_grant_q;
        bus.dbg_data  = dbg_data_q;
        bus.retired   = retired_q;
        bus.state     = state_q;
    end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Testbench for imem_fetch_sequencer: a directed vector table for the basic run,
// hand-written sequences for step, debug, halt, reset and PC wrap, and a randomized
// run compared cycle by cycle against a behavioural model of the sequencer.
module tb_imem_fetch_sequencer;

    localparam int DEPTH = 32;

    logic clk;
    logic reset;
    logic [7:0] imem [DEPTH];

    int checks;
    int errors;

    imem_fetch_sequencer_if bus ();

    imem_fetch_sequencer #(
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.instruction = imem[bus.imem_addr[4:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       run;
        logic       exec_done;
        logic [1:0] e_state;
        logic [7:0] e_pc;
        logic [7:0] e_ir;
        logic       e_iv;
        logic [7:0] e_ret;
    } vec_t;

    vec_t vecs [12];

    // Behavioural model state (plain integers, modes 0=halted 1=fetch 2=exec).
    int         m_mode;
    int         m_pc;
    logic [7:0] m_ir;
    logic       m_iv;
    logic       m_dg;
    logic [7:0] m_dd;
    int         m_ret;
    logic       m_single;
    logic       m_halt_wanted;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic rn, input logic st, input logic hr,
                                  input logic ed, input logic dr, input logic [7:0] da);
        reset        = r;
        bus.run      = rn;
        bus.step     = st;
        bus.halt_req = hr;
        bus.exec_done = ed;
        bus.dbg_req  = dr;
        bus.dbg_addr = da;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_program();
        for (int i = 0; i < DEPTH; i++) imem[i] = 8'h00;
        imem[0] = 8'h49;
        imem[1] = 8'hC1;
        imem[2] = 8'h18;
        imem[3] = 8'hA9;
        imem[4] = 8'h4D;
    endtask

    function automatic int model_addr();
        if (m_mode == 0 && bus.dbg_req) return int'(bus.dbg_addr);
        return m_pc;
    endfunction

    // One clock edge of the reference behaviour, computed from the current inputs.
    task automatic model_edge();
        int         addr;
        logic [7:0] word;
        int         offset;
        if (reset) begin
            m_mode = 0; m_pc = 0; m_ir = 8'h00; m_iv = 1'b0; m_dg = 1'b0;
            m_dd = 8'h00; m_ret = 0; m_single = 1'b0; m_halt_wanted = 1'b0;
            return;
        end
        addr = model_addr();
        word = imem[addr % DEPTH];
        m_iv = 1'b0;
        m_dg = 1'b0;
        if (m_mode == 0) begin
            if (bus.run) begin
                m_mode = 1; m_single = 1'b0;
            end else if (bus.step) begin
                m_mode = 1; m_single = 1'b1;
            end else if (bus.dbg_req) begin
                m_dd = word; m_dg = 1'b1;
            end
        end else if (m_mode == 1) begin
            m_ir = word;
            m_iv = 1'b1;
            if (bus.halt_req) m_halt_wanted = 1'b1;
            m_mode = 2;
        end else begin
            if (bus.exec_done) begin
                m_ret = (m_ret + 1) % 256;
                if (m_ir[7:6] == 2'b11)
                    offset = m_ir[5] ? int'(m_ir[5:0]) - 64 : int'(m_ir[5:0]);
                else
                    offset = 1;
                m_pc = (((m_pc + offset) % DEPTH) + DEPTH) % DEPTH;
                if (m_halt_wanted || bus.halt_req || m_single) begin
                    m_mode = 0; m_halt_wanted = 1'b0; m_single = 1'b0;
                end else begin
                    m_mode = 1;
                end
            end else if (bus.halt_req) begin
                m_halt_wanted = 1'b1;
            end
        end
    endtask

    task automatic check_output();
        check("rand_state", 8'(bus.state), 8'(m_mode));
        check("rand_pc", bus.pc, 8'(m_pc));
        check("rand_ir", bus.ir, m_ir);
        check("rand_ir_valid", 8'(bus.ir_valid), 8'(m_iv));
        check("rand_dbg_grant", 8'(bus.dbg_grant), 8'(m_dg));
        check("rand_dbg_data", bus.dbg_data, m_dd);
        check("rand_retired", bus.retired, 8'(m_ret));
    endtask

    initial begin
        int pulses;
        checks = 0;
        errors = 0;

        //         rst  run  ed   state  pc     ir     iv   ret
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'b10, 8'h00, 8'h49, 1'b1, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'b01, 8'h01, 8'h49, 1'b0, 8'd1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'b10, 8'h01, 8'hC1, 1'b1, 8'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'b01, 8'h02, 8'hC1, 1'b0, 8'd2};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'b10, 8'h02, 8'h18, 1'b1, 8'd2};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'b01, 8'h03, 8'h18, 1'b0, 8'd3};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'b10, 8'h03, 8'hA9, 1'b1, 8'd3};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 2'b01, 8'h04, 8'hA9, 1'b0, 8'd4};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 2'b10, 8'h04, 8'h4D, 1'b1, 8'd4};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 2'b01, 8'h05, 8'h4D, 1'b0, 8'd5};

        load_program();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);

        // Free-running program with exec_done tied high.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].run, 1'b0, 1'b0, vecs[i].exec_done, 1'b0, 8'h00);
            cycle();
            check($sformatf("vec%0d_state", i), 8'(bus.state), 8'(vecs[i].e_state));
            check($sformatf("vec%0d_pc", i), bus.pc, vecs[i].e_pc);
            check($sformatf("vec%0d_ir", i), bus.ir, vecs[i].e_ir);
            check($sformatf("vec%0d_ir_valid", i), 8'(bus.ir_valid), 8'(vecs[i].e_iv));
            check($sformatf("vec%0d_retired", i), bus.retired, vecs[i].e_ret);
            check($sformatf("vec%0d_dbg_grant", i), 8'(bus.dbg_grant), 8'h00);
        end

        // Single step from reset.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle();
        check("step_fetch_state", 8'(bus.state), 8'h01);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            cycle();
            if (bus.ir_valid) begin
                pulses++;
                check("step_ir", bus.ir, 8'h49);
            end
        end
        check("step_pulses", 8'(pulses), 8'd1);
        check("step_state", 8'(bus.state), 8'h00);
        check("step_pc", bus.pc, 8'h01);
        check("step_retired", bus.retired, 8'd1);

        // Debug reads while halted.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03);
        #1;
        check("dbg_imem_addr", bus.imem_addr, 8'h03);
        cycle();
        check("dbg_grant", 8'(bus.dbg_grant), 8'h01);
        check("dbg_data", bus.dbg_data, 8'hA9);
        check("dbg_pc", bus.pc, 8'h01);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle();
        check("dbg_held_grant", 8'(bus.dbg_grant), 8'h01);
        check("dbg_held_data", bus.dbg_data, 8'h49);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03);
        cycle();
        check("dbg_run_grant", 8'(bus.dbg_grant), 8'h00);
        check("dbg_run_state", 8'(bus.state), 8'h01);

        // Halt requested while EXEC is stalled.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        check("fetch_imem_addr", bus.imem_addr, 8'h01);
        cycle();
        check("halt_exec_ir", bus.ir, 8'hC1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle();
        check("halt_stall1", 8'(bus.state), 8'h02);
        check("halt_stall1_iv", 8'(bus.ir_valid), 8'h00);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        check("halt_stall2", 8'(bus.state), 8'h02);
        cycle();
        check("halt_stall3", 8'(bus.state), 8'h02);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle();
        check("halt_state", 8'(bus.state), 8'h00);
        check("halt_pc", bus.pc, 8'h02);
        check("halt_retired", bus.retired, 8'd2);
        cycle();
        check("halt_stays", 8'(bus.state), 8'h00);

        // Reset in the middle of EXEC.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        check("rst_pre_state", 8'(bus.state), 8'h02);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle();
        check("rst_state", 8'(bus.state), 8'h00);
        check("rst_pc", bus.pc, 8'h00);
        check("rst_ir", bus.ir, 8'h00);
        check("rst_iv", 8'(bus.ir_valid), 8'h00);
        check("rst_retired", bus.retired, 8'd0);

        // Backward jump FF at pc=4.
        imem[4] = 8'hFF;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 11; i++) cycle();
        check("jmpback_ir", bus.ir, 8'hFF);
        check("jmpback_pc", bus.pc, 8'h03);
        check("jmpback_retired", bus.retired, 8'd5);

        // Backward jump from 0 wraps to 31, then sequential 31 wraps to 0.
        imem[0]  = 8'hFF;
        imem[31] = 8'h00;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle();
        cycle();
        cycle();
        check("wrap_pc31", bus.pc, 8'd31);
        cycle();
        cycle();
        check("wrap_pc0", bus.pc, 8'd0);
        check("wrap_retired", bus.retired, 8'd2);

        // Randomized run against the behavioural model.
        for (int i = 0; i < DEPTH; i++) imem[i] = 8'($urandom);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        model_edge();
        cycle();
        check_output();
        for (int n = 0; n < 3000; n++) begin
            apply_stimulus($urandom_range(0, 63) == 0,
                           $urandom_range(0, 7) == 0,
                           $urandom_range(0, 5) == 0,
                           $urandom_range(0, 7) == 0,
                           $urandom_range(0, 1) == 0,
                           $urandom_range(0, 1) == 0,
                           8'($urandom));
            #1;
            if (!reset) check("rand_imem_addr", bus.imem_addr, 8'(model_addr()));
            model_edge();
            cycle();
            check_output();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
